// File: rtl/nios_memory_dp.sv
// Dual-port byte-enabled word memory with 1- or 2-cycle read latency and a shared clock enable.
// Define NIOS_MEMORY_RDW_NEWDATA_EN so same-cycle read-during-write returns the merged new word.
// Handshake: a read is accepted at any enabled edge with chipselect & read (no waitrequest);
// its result is qualified by a one-cycle readdatavalid pulse after the configured latency.
module nios_memory_dp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 5320,
  parameter int OUT_REG   = 0,
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  input  logic                freeze,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Index 0 is port s1, index 1 is port s2.
  logic [ADDR_W-1:0] addr     [2];
  logic [NB-1:0]     be       [2];
  logic [DATA_W-1:0] wdata    [2];
  logic              cs       [2];
  logic              rd       [2];
  logic              wr       [2];
  logic              in_range [2];
  logic              acc_rd   [2];
  logic              acc_wr   [2];
  logic [DATA_W-1:0] rd_word  [2];
  logic [DATA_W-1:0] rdata    [2];
  logic              rvalid   [2];
  logic              en;

  assign en = clken & ~reset_req;

  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;
  assign cs[0]    = s1_chipselect;
  assign cs[1]    = s2_chipselect;
  assign rd[0]    = s1_read;
  assign rd[1]    = s2_read;
  assign wr[0]    = s1_write;
  assign wr[1]    = s2_write;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_range[p] = int'(addr[p]) < DEPTH;
      acc_rd[p]   = cs[p] & rd[p];
      acc_wr[p]   = cs[p] & wr[p] & ~freeze & in_range[p];
    end
  end

  // Port s2 lanes are written first so s1 overrides on lanes both ports enable.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_wr[1] && be[1][i]) mem[addr[1]][8*i +: 8] <= wdata[1][8*i +: 8];
        if (acc_wr[0] && be[0][i]) mem[addr[0]][8*i +: 8] <= wdata[0][8*i +: 8];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = '0;
      if (in_range[p]) begin
        rd_word[p] = mem[addr[p]];
`ifdef NIOS_MEMORY_RDW_NEWDATA_EN
        for (int i = 0; i < NB; i++) begin
          if (acc_wr[1] && addr[1] == addr[p] && be[1][i])
            rd_word[p][8*i +: 8] = wdata[1][8*i +: 8];
          if (acc_wr[0] && addr[0] == addr[p] && be[0][i])
            rd_word[p][8*i +: 8] = wdata[0][8*i +: 8];
        end
`endif
      end
    end
  end

  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      logic              v1;
      logic [DATA_W-1:0] d1;
      logic              v_out;
      logic [DATA_W-1:0] d_out;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v1 <= 1'b0;
          d1 <= '0;
        end else if (en) begin
          v1 <= acc_rd[p];
          if (acc_rd[p]) d1 <= rd_word[p];
        end
      end

      if (OUT_REG != 0) begin : g_out_reg
        logic              v2;
        logic [DATA_W-1:0] d2;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            v2 <= 1'b0;
            d2 <= '0;
          end else if (en) begin
            v2 <= v1;
            if (v1) d2 <= d1;
          end
        end

        assign v_out = v2;
        assign d_out = d2;
      end else begin : g_no_reg
        assign v_out = v1;
        assign d_out = d1;
      end

      // A stalled result stays parked in its register and is only shown once en returns.
      assign rdata[p]  = reset ? '0 : d_out;
      assign rvalid[p] = ~reset & en & v_out;
    end
  endgenerate

  assign s1_readdata      = rdata[0];
  assign s1_readdatavalid = rvalid[0];
  assign s2_readdata      = rdata[1];
  assign s2_readdatavalid = rvalid[1];

endmodule

// File: tb/tb_nios_memory_dp.sv
// Bench for nios_memory_dp: one OUT_REG=0 and one OUT_REG=1 instance share stimulus and a reference model.
`timescale 1ns/1ps
module tb_nios_memory_dp;

    localparam int DW    = 32;
    localparam int AW    = 13;
    localparam int DEPTH = 5320;
    localparam int NB    = DW / 8;

    logic          clk = 1'b0;
    logic          reset, clken, reset_req, freeze;
    logic [AW-1:0] addr [2];
    logic [NB-1:0] be   [2];
    logic          cs   [2];
    logic          rd   [2];
    logic          wr   [2];
    logic [DW-1:0] wd   [2];

    logic [DW-1:0] r0_s1_data, r0_s2_data, r1_s1_data, r1_s2_data;
    logic          r0_s1_valid, r0_s2_valid, r1_s1_valid, r1_s2_valid;

    always #5 clk = ~clk;

    nios_memory_dp #(.OUT_REG(0)) dut0 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .s1_address(addr[0]), .s1_byteenable(be[0]), .s1_chipselect(cs[0]),
        .s1_read(rd[0]), .s1_write(wr[0]), .s1_writedata(wd[0]),
        .s1_readdata(r0_s1_data), .s1_readdatavalid(r0_s1_valid),
        .s2_address(addr[1]), .s2_byteenable(be[1]), .s2_chipselect(cs[1]),
        .s2_read(rd[1]), .s2_write(wr[1]), .s2_writedata(wd[1]),
        .s2_readdata(r0_s2_data), .s2_readdatavalid(r0_s2_valid)
    );

    nios_memory_dp #(.OUT_REG(1)) dut1 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .s1_address(addr[0]), .s1_byteenable(be[0]), .s1_chipselect(cs[0]),
        .s1_read(rd[0]), .s1_write(wr[0]), .s1_writedata(wd[0]),
        .s1_readdata(r1_s1_data), .s1_readdatavalid(r1_s1_valid),
        .s2_address(addr[1]), .s2_byteenable(be[1]), .s2_chipselect(cs[1]),
        .s2_read(rd[1]), .s2_write(wr[1]), .s2_writedata(wd[1]),
        .s2_readdata(r1_s2_data), .s2_readdatavalid(r1_s2_valid)
    );

    // Reference model: word array, enabled-edge count, and per-port accepted reads.
    typedef struct {
        int            n;
        logic [DW-1:0] d;
    } rd_t;

    logic [DW-1:0] mm [0:DEPTH-1];
    rd_t           exp_q [2][$];
    logic [DW-1:0] base [2];
    int            e_cnt;
    int            n_asserts = 0;
    int            n_fail    = 0;

    function automatic logic [DW-1:0] get_data(int dv, int p);
        if (dv == 0) return (p == 0) ? r0_s1_data : r0_s2_data;
        return (p == 0) ? r1_s1_data : r1_s2_data;
    endfunction

    function automatic logic get_valid(int dv, int p);
        if (dv == 0) return (p == 0) ? r0_s1_valid : r0_s2_valid;
        return (p == 0) ? r1_s1_valid : r1_s2_valid;
    endfunction

    function automatic logic [DW-1:0] mread(int a);
        return (a < DEPTH) ? mm[a] : '0;
    endfunction

    // Data the port shows for a given latency: the newest read old enough to have emerged.
    function automatic logic [DW-1:0] presented(int p, int lat);
        logic [DW-1:0] v = base[p];
        for (int k = 0; k < exp_q[p].size(); k++)
            if (exp_q[p][k].n <= e_cnt - lat + 1) v = exp_q[p][k].d;
        return v;
    endfunction

    task automatic check_bit(string tag, logic obs, logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < 2; p++) begin
            exp_q[p].delete();
            base[p] = '0;
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] r [2];
        rd_t           t;
        if (reset) begin
            model_clear();
            return;
        end
        if (!(clken && !reset_req)) return;
        e_cnt++;
        for (int p = 0; p < 2; p++) r[p] = mread(int'(addr[p]));
        if (!freeze) begin
            for (int p = 1; p >= 0; p--)
                if (cs[p] && wr[p] && int'(addr[p]) < DEPTH)
                    for (int i = 0; i < NB; i++)
                        if (be[p][i]) mm[int'(addr[p])][8*i +: 8] = wd[p][8*i +: 8];
        end
`ifdef NIOS_MEMORY_RDW_NEWDATA_EN
        for (int p = 0; p < 2; p++) r[p] = mread(int'(addr[p]));
`endif
        for (int p = 0; p < 2; p++) begin
            if (cs[p] && rd[p]) begin
                t.n = e_cnt;
                t.d = r[p];
                exp_q[p].push_back(t);
                while (exp_q[p].size() > 3) base[p] = exp_q[p].pop_front().d;
            end
        end
    endtask

    task automatic check_outputs();
        logic en_now = clken && !reset_req;
        for (int dv = 0; dv < 2; dv++) begin
            for (int p = 0; p < 2; p++) begin
                int            lat   = dv + 1;
                logic          v_exp = 1'b0;
                logic [DW-1:0] d_exp = presented(p, lat);
                for (int k = 0; k < exp_q[p].size(); k++)
                    if (exp_q[p][k].n == e_cnt - lat + 1) v_exp = en_now && !reset;
                if (reset) d_exp = '0;
                check_bit($sformatf("valid lat%0d s%0d", lat, p + 1), get_valid(dv, p), v_exp);
                if (v_exp || !en_now || reset)
                    check_word($sformatf("data lat%0d s%0d", lat, p + 1), get_data(dv, p), d_exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            cs[p] = 1'b0;
            rd[p] = 1'b0;
            wr[p] = 1'b0;
            be[p] = '0;
        end
    endtask

    task automatic drive_rd(int p, int a);
        cs[p]   = 1'b1;
        rd[p]   = 1'b1;
        addr[p] = AW'(a);
    endtask

    task automatic drive_wr(int p, int a, logic [DW-1:0] d, logic [NB-1:0] b);
        cs[p]   = 1'b1;
        wr[p]   = 1'b1;
        addr[p] = AW'(a);
        wd[p]   = d;
        be[p]   = b;
    endtask

    task automatic check_all_zero(string tag);
        for (int dv = 0; dv < 2; dv++)
            for (int p = 0; p < 2; p++) begin
                check_bit($sformatf("%s valid dut%0d s%0d", tag, dv, p + 1), get_valid(dv, p), 1'b0);
                check_word($sformatf("%s data dut%0d s%0d", tag, dv, p + 1), get_data(dv, p), '0);
            end
    endtask

    task automatic do_reset();
        idle();
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check_all_zero("async_reset");
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        model_clear();
        e_cnt     = 0;
        reset     = 1'b1;
        clken     = 1'b1;
        reset_req = 1'b0;
        freeze    = 1'b0;
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0;
            wd[p]   = '0;
        end
        idle();
        #1;
        check_all_zero("reset_state");
        step();
        step();
        reset = 1'b0;
        step();

        // Write then read on the other port.
        drive_wr(0, 5, 32'hDEADBEEF, 4'b1111);
        step();
        idle();
        drive_rd(1, 5);
        step();
        check_bit("wr_rd valid", r0_s2_valid, 1'b1);
        check_word("wr_rd data", r0_s2_data, 32'hDEADBEEF);
        idle();
        step();
        check_word("wr_rd data lat2", r1_s2_data, 32'hDEADBEEF);
        step();

        // Same-address dual write, lane arbitration.
        drive_wr(0, 7, 32'h000000AA, 4'b0001);
        drive_wr(1, 7, 32'h0000BB00, 4'b0011);
        step();
        idle();
        drive_rd(0, 7);
        step();
        check_word("collide data", r0_s1_data, 32'h0000BBAA);
        idle();
        step();

        // Read during write, cross-port and same-port.
        drive_wr(0, 9, 32'h11111111, 4'b1111);
        step();
        drive_wr(0, 9, 32'h22222222, 4'b1111);
        drive_rd(1, 9);
        step();
`ifdef NIOS_MEMORY_RDW_NEWDATA_EN
        check_word("rdw data", r0_s2_data, 32'h22222222);
`else
        check_word("rdw data", r0_s2_data, 32'h11111111);
`endif
        idle();
        drive_wr(0, 10, 32'h55AA55AA, 4'b0110);
        drive_rd(0, 10);
        step();
        idle();
        step();

        // Streamed reads with a two-cycle clock-enable stall.
        drive_wr(0, 1, 32'h00000101, 4'b1111);
        drive_wr(1, 2, 32'h00000202, 4'b1111);
        step();
        idle();
        drive_wr(0, 3, 32'h00000303, 4'b1111);
        step();
        idle();
        drive_rd(0, 1);
        step();
        check_bit("stream first lat2", r1_s1_valid, 1'b0);
        drive_rd(0, 2);
        step();
        check_word("stream d1", r1_s1_data, 32'h00000101);
        drive_rd(0, 3);
        step();
        check_word("stream d2", r1_s1_data, 32'h00000202);
        idle();
        clken = 1'b0;
        step();
        check_bit("stall valid", r1_s1_valid, 1'b0);
        step();
        check_word("stall hold", r1_s1_data, 32'h00000202);
        clken = 1'b1;
        step();
        check_bit("resume valid", r1_s1_valid, 1'b1);
        check_word("resume d3", r1_s1_data, 32'h00000303);
        step();

        // Freeze and out-of-range accesses.
        freeze = 1'b1;
        drive_wr(0, 0, 32'hFFFFFFFF, 4'b1111);
        step();
        freeze = 1'b0;
        idle();
        drive_rd(0, 0);
        drive_rd(1, DEPTH);
        step();
        check_word("freeze data", r0_s1_data, 32'h0);
        check_bit("oor valid", r0_s2_valid, 1'b1);
        check_word("oor data", r0_s2_data, 32'h0);
        idle();
        step();

        // Reset with a read in flight.
        drive_rd(0, 5);
        step();
        do_reset();
        step();
        step();
        check_bit("no stale pulse", r1_s1_valid, 1'b0);
        drive_rd(0, 5);
        drive_rd(1, 7);
        step();
        check_word("after reset s1", r0_s1_data, 32'hDEADBEEF);
        check_word("after reset s2", r0_s2_data, 32'h0000BBAA);
        idle();
        step();
        step();

        // Random traffic over a narrow address window.
        for (int c = 0; c < 400; c++) begin
            idle();
            if (c % 97 == 50) begin
                do_reset();
                continue;
            end
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            freeze    = ($urandom_range(0, 7) == 0);
            for (int p = 0; p < 2; p++) begin
                cs[p]   = ($urandom_range(0, 5) != 0);
                rd[p]   = 1'($urandom_range(0, 1));
                wr[p]   = 1'($urandom_range(0, 1));
                addr[p] = ($urandom_range(0, 9) == 0) ? AW'(DEPTH - 4 + $urandom_range(0, 7))
                                                      : AW'($urandom_range(0, 7));
                be[p]   = NB'($urandom);
                wd[p]   = $urandom;
            end
            step();
        end
        idle();
        clken     = 1'b1;
        reset_req = 1'b0;
        freeze    = 1'b0;
        step();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
